// File: rtl/ysyx_040729_wbu.sv
// Write-back unit: retires one instruction per WRITE cycle, waits for load data,
// extracts and extends load results, and drives the register-file write port.
module ysyx_040729_wbu #(
    parameter int DATA_WIDTH = 64,
    parameter int REGI_DEPTH = 32,
    localparam int AW = $clog2(REGI_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rf_wen,
    output logic [AW-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic [63:0]           instret
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wbu_state_t;

    wbu_state_t            state_r;
    logic                  in_ready_r;
    logic [AW-1:0]         rd_r;
    logic                  rd_wen_r;
    logic [2:0]            funct3_r;
    logic [2:0]            off_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic                  rf_wen_r;
    logic [AW-1:0]         rf_waddr_r;
    logic [DATA_WIDTH-1:0] rf_wdata_r;
    logic                  commit_valid_r;
    logic [DATA_WIDTH-1:0] commit_pc_r;
    logic [63:0]           instret_r;

    logic                  handshake_s;
    logic [DATA_WIDTH-1:0] load_data_s;

    // Selects the addressed byte/half/word of the aligned memory word; offset
    // bits below the access size are dropped so misaligned loads never trap.
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [2:0]            funct3,
        input logic [2:0]            off,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[2:1], 4'b0000});
        w = 32'(word >> {off[2], 5'b00000});
        case (funct3)
            3'b000:  load_extend = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  load_extend = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  load_extend = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  load_extend = {{(DATA_WIDTH-16){1'b0}}, h};
            3'b010:  load_extend = {{(DATA_WIDTH-32){w[31]}}, w};
            3'b110:  load_extend = {{(DATA_WIDTH-32){1'b0}}, w};
            default: load_extend = word;
        endcase
    endfunction

    assign handshake_s = in_valid & in_ready_r;
    assign load_data_s = load_extend(funct3_r, off_r, mem_rdata);

    // Control FSM with registered write-port, commit and retire-count outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            in_ready_r     <= 1'b1;
            rd_r           <= {AW{1'b0}};
            rd_wen_r       <= 1'b0;
            funct3_r       <= 3'b000;
            off_r          <= 3'b000;
            pc_r           <= {DATA_WIDTH{1'b0}};
            rf_wen_r       <= 1'b0;
            rf_waddr_r     <= {AW{1'b0}};
            rf_wdata_r     <= {DATA_WIDTH{1'b0}};
            commit_valid_r <= 1'b0;
            commit_pc_r    <= {DATA_WIDTH{1'b0}};
            instret_r      <= 64'd0;
        end else begin
            if (state_r == ST_WRITE) begin
                instret_r <= instret_r + 64'd1;
            end else begin
                instret_r <= instret_r;
            end
            case (state_r)
                ST_IDLE, ST_WRITE: begin
                    if (handshake_s) begin
                        rd_r     <= in_rd;
                        rd_wen_r <= in_rd_wen;
                        funct3_r <= in_funct3;
                        off_r    <= in_result[2:0];
                        pc_r     <= in_pc;
                        if (in_is_load) begin
                            state_r        <= ST_WAIT_MEM;
                            in_ready_r     <= 1'b0;
                            rf_wen_r       <= 1'b0;
                            commit_valid_r <= 1'b0;
                        end else begin
                            // Non-loads go straight to WRITE with the ALU result.
                            state_r        <= ST_WRITE;
                            in_ready_r     <= 1'b1;
                            rf_wen_r       <= in_rd_wen && (in_rd != {AW{1'b0}});
                            rf_waddr_r     <= in_rd;
                            rf_wdata_r     <= in_result;
                            commit_valid_r <= 1'b1;
                            commit_pc_r    <= in_pc;
                        end
                    end else begin
                        state_r        <= ST_IDLE;
                        in_ready_r     <= 1'b1;
                        rf_wen_r       <= 1'b0;
                        commit_valid_r <= 1'b0;
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state_r        <= ST_WRITE;
                        in_ready_r     <= 1'b1;
                        rf_wen_r       <= rd_wen_r && (rd_r != {AW{1'b0}});
                        rf_waddr_r     <= rd_r;
                        rf_wdata_r     <= load_data_s;
                        commit_valid_r <= 1'b1;
                        commit_pc_r    <= pc_r;
                    end else begin
                        state_r        <= ST_WAIT_MEM;
                        in_ready_r     <= 1'b0;
                        rf_wen_r       <= 1'b0;
                        commit_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    in_ready_r     <= 1'b1;
                    rf_wen_r       <= 1'b0;
                    commit_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign rf_wen       = rf_wen_r;
    assign rf_waddr     = rf_waddr_r;
    assign rf_wdata     = rf_wdata_r;
    assign commit_valid = commit_valid_r;
    assign commit_pc    = commit_pc_r;
    assign instret      = instret_r;

endmodule
